// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver: LSB-first frames, registered done strobe and error flags.
// Optional parity bit is compiled in with `UART_RX_PARITY_EN.
module uart_rx_oversampled #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int unsigned NW      = $clog2(DBIT);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [4:0] SB_LAST   = 5'(SB_TICK - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [4:0]      s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic [DBIT-1:0] b_d;

  always_comb begin
    b_d = {rx_s_q, b_q[DBIT-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic p_q;
  logic perr_d;

  always_comb begin
    perr_d = (^b_q) ^ p_q ^ PAR_ODD;
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_q          <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_done_tick <= 1'b0;
      case (state_q)
        // Start detection is tick-independent; a coincident tick is deliberately not counted.
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == 5'd7) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == 5'd15) begin
              s_q <= '0;
              b_q <= b_d;
              if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s_q == 5'd15) begin
              p_q     <= rx_s_q;
              s_q     <= '0;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s_q == SB_LAST) begin
              state_q      <= IDLE;
              rx_done_tick <= 1'b1;
              dout         <= b_q;
              frame_err    <= ~rx_s_q;
`ifdef UART_RX_PARITY_EN
              parity_err   <= perr_d;
`else
              parity_err   <= 1'b0;
`endif
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: directed frames plus random traffic,
// checked against a tick-indexed frame decoder model of the serial line.
module tb_uart_rx_oversampled;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int PODD    = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_T = 16 * (1 + DBIT + PBITS) + SB_TICK;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            frame_err;
  logic            parity_err;

  typedef struct {
    int              t;
    logic [DBIT-1:0] d;
    logic            fe;
    logic            pe;
  } rec_t;

  rec_t            obs_q[$];
  rec_t            exp_q[$];
  logic            line_q[$];
  int              tick_idx = 0;
  int              total = 0;
  int              bad = 0;
  logic [DBIT-1:0] last_dout = '0;
  logic            prev_done = 1'b0;
  logic            unused_par;

  always #5 clk = ~clk;

  uart_rx_oversampled #(
    .DBIT(DBIT),
    .SB_TICK(SB_TICK),
    .PARITY_ODD(PODD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .s_tick(s_tick),
    .rx_done_tick(rx_done_tick),
    .dout(dout),
    .frame_err(frame_err),
    .parity_err(parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rx_done_tick) begin
      rec_t r;
      check("strobe_width", prev_done, 1'b0);
      r.t  = tick_idx;
      r.d  = dout;
      r.fe = frame_err;
      r.pe = parity_err;
      obs_q.push_back(r);
    end
    prev_done = rx_done_tick;
  end

  // One oversampling tick; the line value during the tick is recorded for the model.
  task automatic tick1();
    @(negedge clk);
    s_tick = 1'b1;
    line_q.push_back(rx);
    tick_idx = line_q.size() - 1;
    @(negedge clk);
    s_tick = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) tick1();
  endtask

  task automatic idle(input int n);
    line(1'b1, n);
  endtask

  task automatic send(input logic [DBIT-1:0] d, input logic stop_v, input logic par_v);
    line(1'b0, 16);
    for (int i = 0; i < DBIT; i++) line(d[i], 16);
`ifdef UART_RX_PARITY_EN
    line(par_v, 16);
`else
    unused_par = par_v;
`endif
    line(stop_v, SB_TICK);
  endtask

  // The receiver decides on tick k using the line as it stood during tick k-1
  // (two-flop synchronizer latency).
  function automatic logic seen(input int k);
    return (k == 0) ? 1'b1 : line_q[k-1];
  endfunction

  // Frame decoder: a start is noticed after the first low tick; sample points are
  // start+8, then every 16 ticks, stop after SB_TICK more ticks.
  task automatic model_segment();
    int   n, c, t0, t;
    rec_t r;
    logic p;
    exp_q.delete();
    n = line_q.size();
    c = 0;
    while (c < n) begin
      if (line_q[c]) begin
        c++;
        continue;
      end
      t0 = c + 8;
      if (t0 >= n) break;
      if (seen(t0)) begin
        c = t0;
        continue;
      end
      t = t0 + 16 * (DBIT + PBITS) + SB_TICK;
      if (t >= n) break;
      for (int i = 0; i < DBIT; i++) r.d[i] = seen(t0 + 16 * (i + 1));
      p    = seen(t0 + 16 * (DBIT + 1));
      r.t  = t;
      r.fe = ~seen(t);
      r.pe = (PBITS != 0) ? ((^r.d) ^ p ^ 1'(PODD)) : 1'b0;
      exp_q.push_back(r);
      c = t;
    end
  endtask

  task automatic check_segment(input string tag);
    model_segment();
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_tick%0d", tag, i), obs_q[i].t, exp_q[i].t);
      check($sformatf("%s_dout%0d", tag, i), obs_q[i].d, exp_q[i].d);
      check($sformatf("%s_fe%0d", tag, i), obs_q[i].fe, exp_q[i].fe);
      check($sformatf("%s_pe%0d", tag, i), obs_q[i].pe, exp_q[i].pe);
    end
    if (exp_q.size() > 0) last_dout = exp_q[$].d;
    check({tag, "_hold"}, dout, last_dout);
    line_q.delete();
    obs_q.delete();
    tick_idx = 0;
  endtask

  function automatic logic good_par(input logic [DBIT-1:0] d);
    return (^d) ^ 1'(PODD);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DBIT-1:0] d;
    reset  = 1'b1;
    rx     = 1'b1;
    s_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_done", rx_done_tick, 0);
    check("rst_fe", frame_err, 0);
    check("rst_pe", parity_err, 0);
    reset = 1'b0;
    @(negedge clk);
    idle(10);

    send(8'hA5, 1'b1, good_par(8'hA5));
    idle(4);
    check("a5_dout", dout, 8'hA5);
    check("a5_fe", frame_err, 0);
    check_segment("a5");

    line(1'b0, 4);
    idle(40);
    check_segment("false_start");

    send(8'h3C, 1'b0, good_par(8'h3C));
    check("3c_dout", dout, 8'h3C);
    check("3c_fe", frame_err, 1);
    idle(340);
    check_segment("bad_stop");
    send(8'h5A, 1'b1, good_par(8'h5A));
    idle(4);
    check("5a_dout", dout, 8'h5A);
    check("5a_fe", frame_err, 0);
    check_segment("good_after_bad");

    send(8'h00, 1'b1, good_par(8'h00));
    send(8'hFF, 1'b1, good_par(8'hFF));
    send(8'h81, 1'b1, good_par(8'h81));
    idle(4);
    if (obs_q.size() >= 3) begin
      check("b2b_gap01", obs_q[1].t - obs_q[0].t, FRAME_T);
      check("b2b_gap12", obs_q[2].t - obs_q[1].t, FRAME_T);
      check("b2b_last", obs_q[2].d, 8'h81);
    end
    check_segment("b2b");

    d = 8'hF0;
    line(1'b0, 16);
    for (int i = 0; i < 4; i++) line(d[i], 16);
    line(d[4], 8);
    check_segment("abort_pre");
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_rst_dout", dout, 0);
    check("abort_rst_fe", frame_err, 0);
    check("abort_rst_done", rx_done_tick, 0);
    reset     = 1'b0;
    last_dout = '0;
    @(negedge clk);
    idle(10);
    check_segment("abort_quiet");
    send(8'h12, 1'b1, good_par(8'h12));
    idle(4);
    check("after_rst_dout", dout, 8'h12);
    check_segment("after_rst");

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1);
    idle(4);
    check("par_ok", parity_err, 1'b1 ^ 1'b1 ^ 1'(PODD));
    send(8'h07, 1'b1, 1'b0);
    idle(4);
    check("par_bad", parity_err, 1'b1 ^ 1'b0 ^ 1'(PODD));
    check_segment("parity");
`endif

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        line(1'b0, $urandom_range(1, 6));
      end else begin
        d = DBIT'($urandom);
        send(d, ($urandom_range(0, 7) != 0), good_par(d) ^ ($urandom_range(0, 5) == 0));
      end
      idle($urandom_range(0, 20));
    end
    idle(340);
    check_segment("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
